// File: rtl/msg_load_controller_pkg.sv
// msg_load_controller_pkg: shared SHA-256 message-load constants and FSM state encoding
package msg_load_controller_pkg;
  localparam int MAX_MESSAGE_LENGTH = 55;
  localparam int READ_TO_TRIGGER_LATENCY = 2;
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_SETUP = 3'd1;
  localparam logic [STATE_W-1:0] ST_CLEAR = 3'd2;
  localparam logic [STATE_W-1:0] ST_READ  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DRAIN = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;
endpackage

// File: rtl/msg_load_controller_trigger_delay_line.sv
// trigger_delay_line: N-stage single-bit shift register with synchronous reset
module trigger_delay_line #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [N-1:0] sr;
  // shift the strobe one stage per cycle; reset flushes anything in flight
  always_ff @(posedge clk)
    if (reset) sr <= '0;
    else sr <= N'({sr, d});
  assign q = sr[N-1];
endmodule

// File: rtl/msg_load_controller.sv
// msg_load_controller: reads a message byte-by-byte into the block-assembly datapath and hands the block to the hash core
module msg_load_controller #(
  parameter int MAX_MESSAGE_LENGTH = msg_load_controller_pkg::MAX_MESSAGE_LENGTH,
  parameter int MSG_ADDR_WIDTH = 10,
  parameter int LEN_WIDTH = $clog2(MAX_MESSAGE_LENGTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      xxx__dut__go,
  input  logic [LEN_WIDTH-1:0]      xxx__dut__msg_length,
  output logic [MSG_ADDR_WIDTH-1:0] dut__msg__address,
  output logic                      dut__msg__enable,
  output logic                      dut__msg__write_enable,
  output logic [LEN_WIDTH-1:0]      dp_msg_length,
  output logic                      dp_clear,
  output logic                      dp_trigger,
  output logic                      block_valid,
  input  logic                      block_accept,
  output logic                      busy,
  output logic                      error
);
  import msg_load_controller_pkg::*;
  logic [STATE_W-1:0] state;
  logic [LEN_WIDTH-1:0] byte_cnt;
  logic drain_second;
  logic len_ok;
  logic last_read;
  assign len_ok = xxx__dut__msg_length != '0 && xxx__dut__msg_length <= LEN_WIDTH'(MAX_MESSAGE_LENGTH);
  assign last_read = byte_cnt == dp_msg_length - LEN_WIDTH'(1);
  // sequence SETUP -> CLEAR -> READ (L bytes) -> DRAIN (2 cycles) -> DONE, rejecting bad lengths from IDLE
  always_ff @(posedge clk)
    if (reset) begin
      state <= ST_IDLE;
      byte_cnt <= '0;
      dp_msg_length <= '0;
      drain_second <= 1'b0;
      error <= 1'b0;
    end else begin
      error <= state == ST_IDLE && xxx__dut__go && !len_ok;
      case (state)
        ST_IDLE:
          if (xxx__dut__go && len_ok) begin
            dp_msg_length <= xxx__dut__msg_length;
            byte_cnt <= '0;
            state <= ST_SETUP;
          end
        ST_SETUP: state <= ST_CLEAR;
        ST_CLEAR: state <= ST_READ;
        ST_READ:
          if (last_read) begin
            drain_second <= 1'b0;
            state <= ST_DRAIN;
          end else byte_cnt <= byte_cnt + LEN_WIDTH'(1);
        ST_DRAIN: begin
          drain_second <= 1'b1;
          if (drain_second) state <= ST_DONE;
        end
        ST_DONE: if (block_accept) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  // memory read strobe reaches the datapath after memory latency plus its input register
  trigger_delay_line #(.N(READ_TO_TRIGGER_LATENCY)) u_delay (
    .clk(clk),
    .reset(reset),
    .d(dut__msg__enable),
    .q(dp_trigger)
  );
  assign dut__msg__address = MSG_ADDR_WIDTH'(byte_cnt);
  assign dut__msg__enable = state == ST_READ;
  assign dut__msg__write_enable = 1'b0;
  assign dp_clear = state == ST_CLEAR;
  assign block_valid = state == ST_DONE;
  assign busy = state != ST_IDLE;
endmodule

// File: tb/tb_msg_load_controller.sv
// tb_msg_load_controller: randomized and directed checks against a cycle-timeline reference model
module tb_msg_load_controller;
  logic clk = 1'b0;
  logic reset, go, block_accept;
  logic [6:0] len;
  logic [9:0] addr;
  logic en, we, dp_clear, dp_trigger, block_valid, busy, error;
  logic [6:0] dp_len;
  int errors = 0;
  int checks = 0;
  int last_len = 0;

  always #5 clk = ~clk;

  msg_load_controller dut (
    .clk(clk), .reset(reset), .xxx__dut__go(go), .xxx__dut__msg_length(len),
    .dut__msg__address(addr), .dut__msg__enable(en), .dut__msg__write_enable(we),
    .dp_msg_length(dp_len), .dp_clear(dp_clear), .dp_trigger(dp_trigger),
    .block_valid(block_valid), .block_accept(block_accept), .busy(busy), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag, input int exp_len);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_clear"}, dp_clear, 0);
    chk({tag, "_trig"}, dp_trigger, 0);
    chk({tag, "_valid"}, block_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_dplen"}, dp_len, exp_len);
  endtask

  // go issued in cycle 0: reads in cycles 3..L+2, triggers L+4 at the latest, block ready from L+5
  task automatic run_msg(input int l, input int d, input bit noise);
    go = 1'b1;
    len = 7'(l);
    block_accept = 1'b0;
    for (int k = 1; k <= l + 6 + d; k++) begin
      step;
      chk("enable", en, k >= 3 && k <= l + 2);
      if (k >= 3 && k <= l + 2) chk("address", addr, k - 3);
      chk("trigger", dp_trigger, k >= 5 && k <= l + 4);
      chk("clear", dp_clear, k == 2);
      chk("valid", block_valid, k >= l + 5 && k <= l + 5 + d);
      chk("busy", busy, k <= l + 5 + d);
      chk("error", error, 0);
      chk("we", we, 0);
      chk("dplen", dp_len, l);
      if (dp_clear) chk("clear_excl", en | dp_trigger, 0);
      go = noise && k <= l + 5 + d && (k == 4 || $urandom_range(0, 3) == 0);
      len = 7'($urandom);
      block_accept = k < l + 5 ? (noise ? 1'($urandom_range(0, 1)) : 1'b0) : (k == l + 5 + d);
    end
    go = 1'b0;
    block_accept = 1'b0;
    last_len = l;
  endtask

  task automatic bad_go(input int l);
    go = 1'b1;
    len = 7'(l);
    step;
    go = 1'b0;
    chk("bad_error", error, 1);
    chk_quiet("bad", last_len);
    step;
    chk("bad_error_off", error, 0);
    chk_quiet("bad2", last_len);
  endtask

  initial begin
    reset = 1'b1;
    go = 1'b0;
    len = '0;
    block_accept = 1'b0;
    step;
    step;
    chk_quiet("rst", 0);
    chk("rst_addr", addr, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    run_msg(3, 0, 0);
    run_msg(55, 0, 0);
    bad_go(0);
    bad_go(56);
    run_msg(7, 10, 1);
    go = 1'b1;
    len = 7'd5;
    for (int k = 1; k <= 4; k++) begin
      step;
      go = 1'b0;
    end
    chk("mid_read_en", en, 1);
    chk("mid_read_addr", addr, 1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    last_len = 0;
    chk_quiet("midrst", 0);
    chk("midrst_addr", addr, 0);
    chk("midrst_error", error, 0);
    for (int k = 0; k < 4; k++) begin
      step;
      chk_quiet("postrst", 0);
    end
    run_msg(1, 0, 0);
    for (int i = 0; i < 15; i++) begin
      run_msg($urandom_range(1, 55), $urandom_range(0, 4), 1);
      if ($urandom_range(0, 1) == 1) bad_go($urandom_range(0, 1) == 1 ? 0 : $urandom_range(56, 127));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
